// File: rtl/ppg_pkg.sv
// Shared constants and types for the PPG analog front-end model and its controller.
package ppg_pkg;

  localparam int unsigned ADC_MID   = 128;
  localparam int unsigned ADC_SHIFT = 4;
  localparam int unsigned PGA_MAX   = 7;
  localparam int unsigned PD_W      = 12;

  typedef enum logic {RISE, FALL} wave_state_t;

  function automatic logic [PD_W-1:0] pd_sat(input logic [PD_W+1:0] x);
    return (|x[PD_W+1:PD_W]) ? '1 : x[PD_W-1:0];
  endfunction

endpackage

// File: rtl/ppg_wave_gen.sv
// Free-running triangle generator for the synthetic heartbeat; tick strobes the cycle after w moves.
module ppg_wave_gen
  import ppg_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned WAVE_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] w,
  output logic       tick
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0] STEP = 8'(WAVE_STEP);
  localparam logic [7:0] TOP  = 8'(256 - WAVE_STEP);

  logic [DIV_W-1:0] div;
  wave_state_t      state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      w     <= '0;
      state <= RISE;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (div == DIV_LAST) begin
        div  <= '0;
        tick <= 1'b1;
        if (state == RISE) begin
          w <= w + STEP;
          if (w + STEP >= TOP) state <= FALL;
        end else if (w - STEP <= STEP) begin
          w     <= '0;
          state <= RISE;
        end else begin
          w <= w - STEP;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppg_afe_model.sv
// Behavioural AFE: LED/photodiode with settling, DC compensation, PGA and 8-bit ADC in a 3-stage pipeline.
module ppg_afe_model
  import ppg_pkg::*;
#(
  parameter int unsigned DARK_LEVEL    = 64,
  parameter int unsigned RED_DC        = 2048,
  parameter int unsigned IR_DC         = 2560,
  parameter int unsigned RED_AMP       = 128,
  parameter int unsigned IR_AMP        = 96,
  parameter int unsigned DC_STEP       = 32,
  parameter int unsigned SAMPLE_DIV    = 4,
  parameter int unsigned WAVE_STEP     = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  input  logic       LED_RED,
  input  logic       LED_IR,
  output logic [7:0] ADC
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [PD_W-1:0] DARK_W    = PD_W'(DARK_LEVEL);
  localparam logic [PD_W-1:0] RED_DC_W  = PD_W'(RED_DC);
  localparam logic [PD_W-1:0] IR_DC_W   = PD_W'(IR_DC);
  localparam logic [19:0]     RED_AMP_W = 20'(RED_AMP);
  localparam logic [19:0]     IR_AMP_W  = 20'(IR_AMP);
  localparam logic [12:0]     DC_STEP_W = 13'(DC_STEP);

  logic [7:0]          w;
  logic                tick;
  logic [PD_W-1:0]     ac_red, ac_ir;
  logic [1:0]          led, prev_led;
  logic [SETTLE_W-1:0] settle, settle_next;
  logic [PD_W+1:0]     red_sum, ir_sum;
  logic [PD_W-1:0]     s, s_q;
  logic [6:0]          dc_q;
  logic [3:0]          gain_q;
  logic [12:0]         comp;
  logic signed [12:0]  v;
  logic [2:0]          g;
  logic signed [20:0]  scaled, scaled_q, mid_sum;

  ppg_wave_gen #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .WAVE_STEP (WAVE_STEP)
  ) u_wave (
    .clk  (clk),
    .rst_n(rst_n),
    .w    (w),
    .tick (tick)
  );

  // w only moves on ticks, so the pulsatile products are refreshed once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_red <= '0;
      ac_ir  <= '0;
    end else if (tick) begin
      ac_red <= PD_W'(({12'd0, w} * RED_AMP_W) >> 8);
      ac_ir  <= PD_W'(({12'd0, w} * IR_AMP_W) >> 8);
    end
  end

  // The change edge itself is the first of SETTLE_CYCLES dark samples.
  always_comb begin
    led         = {LED_RED, LED_IR};
    settle_next = (led != prev_led) ? SETTLE_W'(SETTLE_CYCLES)
                : (settle != '0)    ? settle - 1'b1 : '0;
    red_sum     = {2'b00, RED_DC_W} + {2'b00, ac_red};
    ir_sum      = {2'b00, IR_DC_W} + {2'b00, ac_ir};
    case (led)
      2'b10:   s = pd_sat(red_sum);
      2'b01:   s = pd_sat(ir_sum);
      2'b11:   s = pd_sat(red_sum + ir_sum);
      default: s = DARK_W;
    endcase
    if (settle_next != '0) s = DARK_W;
  end

  // DC_Comp/PGA_Gain get a holding register here so every input sees the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      dc_q     <= '0;
      gain_q   <= '0;
      settle   <= '0;
      prev_led <= 2'b00;
    end else begin
      s_q      <= s;
      dc_q     <= DC_Comp;
      gain_q   <= PGA_Gain;
      settle   <= settle_next;
      prev_led <= led;
    end
  end

  always_comb begin
    comp   = {6'd0, dc_q} * DC_STEP_W;
    v      = $signed({1'b0, s_q}) - $signed(comp);
    g      = gain_q[3] ? 3'(PGA_MAX) : gain_q[2:0];
    scaled = {{8{v[12]}}, v} <<< g;
    mid_sum = (scaled_q >>> ADC_SHIFT) + $signed(21'(ADC_MID));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled_q <= '0;
      ADC      <= '0;
    end else begin
      scaled_q <= scaled;
      if (mid_sum[20])          ADC <= '0;
      else if (|mid_sum[19:8])  ADC <= '1;
      else                      ADC <= mid_sum[7:0];
    end
  end

endmodule

// File: tb/tb_ppg_afe_model.sv
// Self-checking bench: two AFE instances (zero and default amplitudes) against a spec-level model.
module tb_ppg_afe_model;

  localparam int DARK = 64, RDC = 2048, IDC = 2560, STEP = 4, DIV = 4, SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] dc_comp = '0;
  logic [3:0] pga_gain = '0;
  logic       led_red = 1'b0;
  logic       led_ir = 1'b0;
  logic [7:0] adc_cal, adc_def;

  int n_checks = 0;
  int n_fail = 0;

  ppg_afe_model #(.RED_AMP(0), .IR_AMP(0)) u_cal (
    .clk(clk), .rst_n(rst_n), .DC_Comp(dc_comp), .PGA_Gain(pga_gain),
    .LED_RED(led_red), .LED_IR(led_ir), .ADC(adc_cal)
  );

  ppg_afe_model u_def (
    .clk(clk), .rst_n(rst_n), .DC_Comp(dc_comp), .PGA_Gain(pga_gain),
    .LED_RED(led_red), .LED_IR(led_ir), .ADC(adc_def)
  );

  always #5 clk = ~clk;

  // Reference model: one triangle period as a table, photodiode/ADC arithmetic in plain ints.
  int wseq[$];
  int q_cal[$], q_def[$];
  int exp_cal, exp_def;
  int m_edges, m_dark, m_w, m_s;
  logic [1:0] m_prev, m_led;
  bit m_is_dark;

  function automatic int wave_at(int j);
    if (j <= 0 || wseq.size() == 0) return 0;
    return wseq[(j / DIV) % wseq.size()];
  endfunction

  function automatic int pd_code(logic [1:0] led, int w, int ramp, int iramp);
    int s;
    if (led == 2'b00) return DARK;
    s = 0;
    if (led[1]) s += RDC + (w * ramp) / 256;
    if (led[0]) s += IDC + (w * iramp) / 256;
    return (s > 4095) ? 4095 : s;
  endfunction

  function automatic int adc_code(int s, int dc, int gain);
    int g, v, x;
    g = (gain > 7) ? 7 : gain;
    v = s - dc * 32;
    x = 128 + ((v * (1 << g)) >>> 4);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0;
      m_prev  = 2'b00;
      m_dark  = 0;
      q_cal   = {128, 128};
      q_def   = {128, 128};
      exp_cal = 0;
      exp_def = 0;
    end else begin
      m_edges++;
      m_led = {led_red, led_ir};
      if (m_led != m_prev) m_dark = SETTLE;
      m_prev = m_led;
      m_is_dark = (m_dark > 0);
      if (m_is_dark) m_dark--;
      m_w = wave_at(m_edges - 2);
      m_s = m_is_dark ? DARK : pd_code(m_led, m_w, 0, 0);
      q_cal.push_back(adc_code(m_s, int'(dc_comp), int'(pga_gain)));
      m_s = m_is_dark ? DARK : pd_code(m_led, m_w, 128, 96);
      q_def.push_back(adc_code(m_s, int'(dc_comp), int'(pga_gain)));
      exp_cal = q_cal.pop_front();
      exp_def = q_def.pop_front();
    end
  end

  task automatic drive(input logic r, input logic i, input int d, input int g);
    led_red = r;
    led_ir = i;
    dc_comp = 7'(d);
    pga_gain = 4'(g);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd0) begin n_fail++; $display("FAIL reset_cal: ADC=%0d expected 0", adc_cal); end
    n_checks++;
    if (adc_def !== 8'd0) begin n_fail++; $display("FAIL reset_def: ADC=%0d expected 0", adc_def); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (adc_def !== 8'(exp_def)) begin n_fail++; $display("FAIL reset_release: ADC=%0d expected %0d", adc_def, exp_def); end
    end
  endtask

  task automatic test_calibrated();
    drive(1, 0, 0, 0);
    repeat (20) @(negedge clk);
    drive(1, 0, 64, 7);
    repeat (2) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd255) begin n_fail++; $display("FAIL cal_latency: ADC=%0d expected 255", adc_cal); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (adc_cal !== 8'd128) begin n_fail++; $display("FAIL cal_point: ADC=%0d expected 128", adc_cal); end
    end
  endtask

  task automatic test_gain_sat();
    drive(0, 1, 64, 0);
    repeat (14) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd160) begin n_fail++; $display("FAIL gain0: ADC=%0d expected 160", adc_cal); end
    drive(0, 1, 64, 3);
    repeat (2) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd160) begin n_fail++; $display("FAIL gain3_early: ADC=%0d expected 160", adc_cal); end
    @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd255) begin n_fail++; $display("FAIL gain3: ADC=%0d expected 255", adc_cal); end
    drive(0, 1, 64, 12);
    repeat (3) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd255) begin n_fail++; $display("FAIL gain12: ADC=%0d expected 255", adc_cal); end
    drive(0, 1, 79, 8);
    repeat (3) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd255) begin n_fail++; $display("FAIL gain8_clamp: ADC=%0d expected 255", adc_cal); end
    drive(0, 1, 79, 2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd136) begin n_fail++; $display("FAIL gain2: ADC=%0d expected 136", adc_cal); end
  endtask

  task automatic test_dark();
    drive(0, 0, 0, 0);
    repeat (12) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd132) begin n_fail++; $display("FAIL dark: ADC=%0d expected 132", adc_cal); end
    drive(0, 0, 127, 7);
    repeat (3) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd0) begin n_fail++; $display("FAIL underflow: ADC=%0d expected 0", adc_cal); end
  endtask

  task automatic test_both_leds();
    drive(1, 1, 127, 0);
    repeat (14) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd129) begin n_fail++; $display("FAIL both_sat: ADC=%0d expected 129", adc_cal); end
  endtask

  task automatic test_settling();
    drive(1, 0, 64, 0);
    repeat (14) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd128) begin n_fail++; $display("FAIL settle_red: ADC=%0d expected 128", adc_cal); end
    drive(0, 1, 64, 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd128) begin n_fail++; $display("FAIL settle_before: ADC=%0d expected 128", adc_cal); end
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      n_checks++;
      if (adc_cal !== 8'd4) begin n_fail++; $display("FAIL settle_dark: sample %0d ADC=%0d expected 4", i, adc_cal); end
    end
    @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd160) begin n_fail++; $display("FAIL settle_ir: ADC=%0d expected 160", adc_cal); end
  endtask

  task automatic test_settle_reload();
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0 && i < 20) drive(i[2], ~i[2], 64, 0);
      @(negedge clk);
      n_checks++;
      if (adc_cal !== 8'(exp_cal)) begin n_fail++; $display("FAIL settle_reload: cycle %0d ADC=%0d expected %0d", i, adc_cal, exp_cal); end
    end
  endtask

  task automatic test_waveform();
    int lo, hi;
    lo = 255;
    hi = 0;
    drive(1, 0, 64, 4);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      n_checks++;
      if (adc_def !== 8'(exp_def)) begin n_fail++; $display("FAIL waveform: cycle %0d ADC=%0d expected %0d", i, adc_def, exp_def); end
      if (i > 20) begin
        if (int'(adc_def) < lo) lo = int'(adc_def);
        if (int'(adc_def) > hi) hi = int'(adc_def);
      end
    end
    n_checks++;
    if (hi != 254) begin n_fail++; $display("FAIL wave_peak: max ADC=%0d expected 254", hi); end
    n_checks++;
    if (lo != 128) begin n_fail++; $display("FAIL wave_floor: min ADC=%0d expected 128", lo); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) begin
        led_red = 1'($urandom_range(1));
        led_ir = 1'($urandom_range(1));
      end
      if ($urandom_range(3) == 0) dc_comp = 7'($urandom_range(127));
      if ($urandom_range(3) == 0) pga_gain = 4'($urandom_range(15));
      @(negedge clk);
      n_checks++;
      if (adc_cal !== 8'(exp_cal)) begin n_fail++; $display("FAIL random_cal: cycle %0d ADC=%0d expected %0d", i, adc_cal, exp_cal); end
      n_checks++;
      if (adc_def !== 8'(exp_def)) begin n_fail++; $display("FAIL random_def: cycle %0d ADC=%0d expected %0d", i, adc_def, exp_def); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 64, 4);
    repeat (150) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (adc_def !== 8'd0) begin n_fail++; $display("FAIL reset_async: ADC=%0d expected 0", adc_def); end
    @(negedge clk);
    n_checks++;
    if (adc_cal !== 8'd0) begin n_fail++; $display("FAIL reset_hold: ADC=%0d expected 0", adc_cal); end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++;
      if (adc_def !== 8'(exp_def)) begin n_fail++; $display("FAIL reset_restart: cycle %0d ADC=%0d expected %0d", i, adc_def, exp_def); end
    end
  endtask

  initial begin
    int w;
    bit up;
    w = 0;
    up = 1'b1;
    wseq.push_back(0);
    do begin
      if (up) begin
        w += STEP;
        if (w >= 256 - STEP) up = 1'b0;
      end else begin
        w -= STEP;
        if (w <= STEP) begin
          w = 0;
          up = 1'b1;
        end
      end
      wseq.push_back(w);
    end while (!(w == 0 && up));
    void'(wseq.pop_back());

    test_reset();
    test_calibrated();
    test_gain_sat();
    test_dark();
    test_both_leds();
    test_settling();
    test_settle_reload();
    test_waveform();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
